text_window_render: RTL and testbench

//  Renders a ROWS x COLS character window from an internal text buffer onto the 640x480 VGA raster.

---
 rtl/text_pkg.sv | 34 +++
 rtl/ascii_rom.sv | 25 ++
 rtl/text_buffer_ram.sv | 24 ++
 rtl/text_window_render.sv | 249 ++++++++++++++++++++++++
 tb/tb_text_window_render.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, colour table and helpers for the text window renderer
package text_pkg;

    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int STATUS_Y = 472;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_WHITE  = 12'hFFF;
    localparam logic [11:0] RGB_STATUS = 12'h0F0;

    // Red-to-blue gradient indexed by screen character column (mod 32)
    localparam logic [11:0] COLOUR_LUT [0:31] = '{
        12'hF00, 12'hF00, 12'hF00, 12'hE01, 12'hE01, 12'hD02, 12'hD02, 12'hC03,
        12'hC03, 12'hB04, 12'hB04, 12'hA05, 12'hA05, 12'h906, 12'h906, 12'h807,
        12'h807, 12'h708, 12'h708, 12'h609, 12'h609, 12'h50A, 12'h50A, 12'h40B,
        12'h40B, 12'h30C, 12'h30C, 12'h20D, 12'h20D, 12'h10E, 12'h10E, 12'h00F
    };

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_e;

    function automatic logic is_printable(logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/ascii_rom.sv
// rtl/ascii_rom.sv - shared 8x16 character glyph ROM, one-cycle synchronous read
module ascii_rom (
    input  logic        clk_i,
    input  logic [11:0] addr_i,
    output logic [7:0]  data_o
);

    // Glyph rows top to bottom, MSB is the leftmost pixel
    localparam logic [127:0] GLYPH_A = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_B = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

    function automatic logic [7:0] glyph_row(logic [7:0] c, logic [3:0] r);
        case (c)
            8'h41:   return GLYPH_A[8*(15-int'(r)) +: 8];
            8'h42:   return GLYPH_B[8*(15-int'(r)) +: 8];
            default: return 8'h00;
        endcase
    endfunction

    // Registered glyph row lookup
    always_ff @(posedge clk_i) begin
        data_o <= glyph_row(addr_i[11:4], addr_i[3:0]);
    end

endmodule

// File: rtl/text_buffer_ram.sv
// rtl/text_buffer_ram.sv - simple dual-port character buffer, read-first on address collision
module text_buffer_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [0:DEPTH-1];

    // Write and read share the edge; the read sees the pre-write contents
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/text_window_render.sv
// rtl/text_window_render.sv - character window renderer with byte-stream text buffer
module text_window_render
    import text_pkg::*;
#(
    parameter int COLS      = 32,
    parameter int ROWS      = 4,
    parameter int X0        = 192,
    parameter int Y0        = 208,
    parameter int BORDER    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    video_on,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    wr_en,
    input  logic [7:0]              wr_char,
    output logic                    wr_ready,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic [11:0]             rgb
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(BLINK_DIV);
    localparam int WIN_W = COLS * CHAR_W;
    localparam int WIN_H = ROWS * CHAR_H;
    localparam int IN_M  = 7;
    localparam int OUT_M = 7 + BORDER;

    wr_state_e      state_q;
    logic [AW-1:0]  clr_addr_q;
    logic           wr_ready_q;
    logic [CW-1:0]  cur_col_q;
    logic [RW-1:0]  cur_row_q;
    logic [RW-1:0]  next_row;
    logic           wr_accept;
    logic [AW-1:0]  cur_addr;
    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [7:0]     ram_wdata;

    logic [BW-1:0]  blink_cnt_q;
    logic           blink_q;

    int             xi;
    int             yi;
    logic           in_win_s0;
    logic           border_s0;
    logic           status_s0;
    logic           hit_s0;
    logic [CW-1:0]  col_s0;
    logic [RW-1:0]  row_s0;
    logic [3:0]     gy_s0;
    logic [AW-1:0]  rd_addr;

    logic           vo_1, win_1, hit_1, border_1, status_1;
    logic [2:0]     bit_1;
    logic [4:0]     lut_1;
    logic [3:0]     gy_1;
    logic [7:0]     char_1;

    logic           vo_2, win_2, hit_2, border_2, status_2;
    logic [2:0]     bit_2;
    logic [4:0]     lut_2;
    logic [7:0]     rom_data;

    logic           pix_on;
    logic [11:0]    rgb_d;
    logic [11:0]    rgb_q;

    assign wr_accept  = wr_en & wr_ready_q;
    assign next_row   = (cur_row_q == RW'(ROWS-1)) ? '0 : cur_row_q + 1'b1;
    assign wr_ready   = wr_ready_q;
    assign cursor_col = cur_col_q;
    assign cursor_row = cur_row_q;
    assign rgb        = rgb_q;

    // Select the buffer cell touched this cycle: clear sweep, printable store or backspace blank
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr_q;
        ram_wdata = CH_SPACE;
        cur_addr  = AW'(int'(cur_row_q) * COLS + int'(cur_col_q));
        if (state_q == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (wr_accept) begin
            if (is_printable(wr_char)) begin
                ram_we    = 1'b1;
                ram_waddr = cur_addr;
                ram_wdata = wr_char;
            end else if ((wr_char == CH_BS) && (cur_col_q != '0)) begin
                ram_we    = 1'b1;
                ram_waddr = cur_addr - 1'b1;
            end
        end
    end

    // Write-port FSM: clear sweep after reset or form feed, cursor movement in idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            wr_ready_q <= 1'b0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == AW'(DEPTH-1)) begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                        clr_addr_q <= '0;
                        cur_col_q  <= '0;
                        cur_row_q  <= '0;
                    end
                end
                ST_IDLE: begin
                    if (wr_accept) begin
                        if (is_printable(wr_char)) begin
                            if (cur_col_q == CW'(COLS-1)) begin
                                cur_col_q <= '0;
                                cur_row_q <= next_row;
                            end else begin
                                cur_col_q <= cur_col_q + 1'b1;
                            end
                        end else if (wr_char == CH_CR) begin
                            cur_col_q <= '0;
                            cur_row_q <= next_row;
                        end else if (wr_char == CH_BS) begin
                            if (cur_col_q != '0) begin
                                cur_col_q <= cur_col_q - 1'b1;
                            end
                        end else if (wr_char == CH_FF) begin
                            state_q    <= ST_CLEAR;
                            wr_ready_q <= 1'b0;
                            clr_addr_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Cursor blink phase: toggles each time the divider wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV-1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // S0: classify the pixel and form the buffer read address
    always_comb begin
        xi        = int'(x);
        yi        = int'(y);
        in_win_s0 = (xi >= X0) && (xi < X0 + WIN_W) && (yi >= Y0) && (yi < Y0 + WIN_H);
        border_s0 = (xi >= X0 - OUT_M) && (xi <= X0 + WIN_W - 1 + OUT_M) &&
                    (yi >= Y0 - OUT_M) && (yi <= Y0 + WIN_H - 1 + OUT_M) &&
                    !((xi >= X0 - IN_M) && (xi <= X0 + WIN_W - 1 + IN_M) &&
                      (yi >= Y0 - IN_M) && (yi <= Y0 + WIN_H - 1 + IN_M));
        status_s0 = (yi >= STATUS_Y);
        col_s0    = CW'((xi - X0) / CHAR_W);
        row_s0    = RW'((yi - Y0) / CHAR_H);
        gy_s0     = 4'(yi - Y0);
        hit_s0    = in_win_s0 && (col_s0 == cur_col_q) && (row_s0 == cur_row_q);
        rd_addr   = AW'(int'(row_s0) * COLS + int'(col_s0));
    end

    text_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (char_1)
    );

    ascii_rom u_rom (
        .clk_i  (clk),
        .addr_i ({char_1, gy_1}),
        .data_o (rom_data)
    );

    // S1/S2: carry pixel attributes alongside the buffer and ROM reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vo_1 <= 1'b0; win_1 <= 1'b0; hit_1 <= 1'b0; border_1 <= 1'b0; status_1 <= 1'b0;
            bit_1 <= '0; lut_1 <= '0; gy_1 <= '0;
            vo_2 <= 1'b0; win_2 <= 1'b0; hit_2 <= 1'b0; border_2 <= 1'b0; status_2 <= 1'b0;
            bit_2 <= '0; lut_2 <= '0;
        end else begin
            vo_1     <= video_on;
            win_1    <= in_win_s0;
            hit_1    <= hit_s0;
            border_1 <= border_s0;
            status_1 <= status_s0;
            bit_1    <= x[2:0];
            lut_1    <= x[7:3];
            gy_1     <= gy_s0;
            vo_2     <= vo_1;
            win_2    <= win_1;
            hit_2    <= hit_1;
            border_2 <= border_1;
            status_2 <= status_1;
            bit_2    <= bit_1;
            lut_2    <= lut_1;
        end
    end

    // S3 colour selection in priority order
    always_comb begin
        pix_on = rom_data[~bit_2] ^ (hit_2 & blink_q);
        rgb_d  = RGB_WHITE;
        if (!vo_2) begin
            rgb_d = RGB_BLACK;
        end else if (win_2) begin
            rgb_d = pix_on ? COLOUR_LUT[lut_2] : RGB_WHITE;
        end else if (border_2) begin
            rgb_d = RGB_BLACK;
        end else if (status_2) begin
            rgb_d = RGB_STATUS;
        end
    end

    // Output pixel register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

endmodule

// File: tb/tb_text_window_render.sv
// tb/tb_text_window_render.sv - scoreboard bench for the text window renderer
module tb_text_window_render;

    localparam int X0 = 192;
    localparam int Y0 = 208;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [9:0] x, y;
    logic       wr_en;
    logic [7:0] wr_char;
    logic       wr_ready;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;
    logic [11:0] rgb;

    text_window_render #(
        .COLS(32), .ROWS(4), .X0(X0), .Y0(Y0), .BORDER(4), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .wr_en(wr_en), .wr_char(wr_char), .wr_ready(wr_ready),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] exp;
        string       tag;
    } sb_ent_t;

    sb_ent_t    sbq[$];
    sb_ent_t    ent;
    int         cyc = 0;
    int         rel = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] mbuf [128];
    int         mcol, mrow;
    logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] lut(int i);
        int v;
        v = i * 15 / 31;
        return {4'(15 - v), 4'h0, 4'(v)};
    endfunction

    function automatic logic [7:0] glyph(logic [7:0] ch, int r);
        if (ch == 8'h41) return glyph_a[r];
        return 8'h00;
    endfunction

    // Reference pixel colour; n = clock edges since reset release that set the blink phase used
    function automatic logic [11:0] exp_pix(int px, int py, bit vo, int n);
        int col, row, dx, dy, d;
        logic [7:0] g;
        bit b, bl;
        if (!vo) return 12'h000;
        if (px >= X0 && px < X0 + 256 && py >= Y0 && py < Y0 + 64) begin
            col = (px - X0) / 8;
            row = (py - Y0) / 16;
            g   = glyph(mbuf[row*32 + col], (py - Y0) % 16);
            b   = g[7 - ((px - X0) % 8)];
            bl  = ((n / 4) % 2) == 1;
            if (b ^ (bl && row == mrow && col == mcol)) return lut((px / 8) % 32);
            return 12'hFFF;
        end
        dx = (px < X0) ? X0 - px : ((px >= X0 + 256) ? px - (X0 + 255) : 0);
        dy = (py < Y0) ? Y0 - py : ((py >= Y0 + 64) ? py - (Y0 + 63) : 0);
        d  = (dx > dy) ? dx : dy;
        if (d >= 8 && d <= 11) return 12'h000;
        if (py >= 472) return 12'h0F0;
        return 12'hFFF;
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            ent = sbq.pop_front();
            chk(ent.tag, {20'h0, rgb}, {20'h0, ent.exp});
        end
    end

    task automatic pix(input int px, input int py, input bit vo, input string tag);
        x        = 10'(px);
        y        = 10'(py);
        video_on = vo;
        sbq.push_back('{cyc + 3, exp_pix(px, py, vo, cyc + 2 - rel), tag});
        @(posedge clk); #1;
    endtask

    task automatic flush();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            mbuf[mrow*32 + mcol] = c;
            mcol++;
            if (mcol == 32) begin mcol = 0; mrow = (mrow + 1) % 4; end
        end else if (c == 8'h0D) begin
            mcol = 0; mrow = (mrow + 1) % 4;
        end else if (c == 8'h08) begin
            if (mcol > 0) begin mcol--; mbuf[mrow*32 + mcol] = 8'h20; end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < 128; i++) mbuf[i] = 8'h20;
            mcol = 0; mrow = 0;
        end
    endtask

    task automatic wr(input logic [7:0] c);
        chk("wr_ready", {31'h0, wr_ready}, 32'h1);
        wr_en   = 1'b1;
        wr_char = c;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        model_wr(c);
    endtask

    task automatic chk_cur(input string tag);
        chk(tag, {25'h0, cursor_row, cursor_col}, 32'(mrow * 32 + mcol));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!wr_ready && n < 400) begin @(posedge clk); #1; n++; end
        chk(tag, {31'h0, wr_ready}, 32'h1);
    endtask

    task automatic render_cells(input string tag);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                pix(X0 + c*8, Y0 + r*16 + 7, 1'b1, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0; wr_en = 1'b0; wr_char = '0;
        for (int i = 0; i < 128; i++) mbuf[i] = 8'h20;
        mcol = 0; mrow = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", {20'h0, rgb}, 32'h0);
        chk("rst_ready", {31'h0, wr_ready}, 32'h0);
        chk("rst_cursor", {25'h0, cursor_row, cursor_col}, 32'h0);
        reset = 1'b0;
        rel = cyc;
        n = 0;
        while (!wr_ready && n < 1000) begin @(posedge clk); #1; n++; end
        chk("clear_cycles", 32'(n), 32'd128);
        render_cells("init_space");

        wr(8'h41);
        chk_cur("cur_after_A");
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++)
                pix(X0 + c, Y0 + r, 1'b1, "glyph_A");

        wr(8'h0C);
        wait_ready("ff_done1");
        for (int i = 0; i < 32; i++) wr(8'h41);
        chk_cur("cur_row_end");
        wr(8'h08);
        chk_cur("bs_col0");
        pix(X0 + 31*8, Y0 + 7, 1'b1, "bs_col0_cell");
        wr(8'h41);
        wr(8'h08);
        chk_cur("bs_col1");
        pix(X0, Y0 + 16 + 7, 1'b1, "bs_col1_cell");
        for (int i = 0; i < 96; i++) wr(8'h41);
        chk_cur("cur_wrap");
        render_cells("full_A");

        for (int i = 0; i < 5; i++) wr(8'h41);
        wr(8'h0C);
        wr_en = 1'b1; wr_char = 8'h41;
        repeat (20) @(posedge clk);
        #1;
        wr_en = 1'b0;
        wait_ready("ff_done2");
        chk_cur("cur_after_ff");
        render_cells("cleared");

        wr(8'h01);
        wr(8'h7F);
        chk_cur("ignored_codes");
        wr(8'h41);
        wr(8'h41);
        wr(8'h0D);
        chk_cur("cur_cr");
        wr(8'h41);
        wr(8'h41);
        chk_cur("cur_2_1");
        for (int i = 0; i < 16; i++) pix(X0 + 19, Y0 + 21, 1'b1, "blink");

        pix(X0 - 8, Y0, 1'b1, "border_left");
        pix(X0 - 11, Y0, 1'b1, "border_outer");
        pix(X0 - 12, Y0, 1'b1, "outside_border");
        pix(X0 - 7, Y0, 1'b1, "margin");
        pix(X0 + 256 + 7, Y0 + 5, 1'b1, "border_right");
        pix(X0 + 100, Y0 - 8, 1'b1, "border_top");
        pix(100, 475, 1'b1, "status_bar");
        pix(X0, Y0 + 7, 1'b0, "video_off");
        pix(10, 10, 1'b1, "background");
        flush();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
